// File: rtl/gate_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_bist_pkg
// Purpose  : Shared types and constants for the gate BIST checker family.
// Revision : 1.0 - initial release
// ============================================================================
package gate_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int NUM_VECTORS = 8;
    localparam int VEC_W       = 3;
    localparam int NUM_GATES   = 5;
    localparam int CNT_W       = 4;

    // Position of each stimulus bit inside the vector index ({a,b,sel}).
    localparam int A_BIT   = 2;
    localparam int B_BIT   = 1;
    localparam int SEL_BIT = 0;

    // Bit positions inside fail_mask and the golden/observed gate vectors.
    localparam int FM_AND = 0;
    localparam int FM_OR  = 1;
    localparam int FM_XOR = 2;
    localparam int FM_NOT = 3;
    localparam int FM_MUX = 4;

endpackage : gate_bist_pkg
`default_nettype wire

// File: rtl/gate_golden_model.sv
`default_nettype none
// ============================================================================
// Module   : gate_golden_model
// Purpose  : Combinational reference outputs for and/or/xor/not/mux gates.
// Revision : 1.0 - initial release
// ============================================================================
module gate_golden_model
    import gate_bist_pkg::*;
(
    input  logic                 a_i,
    input  logic                 b_i,
    input  logic                 sel_i,
    output logic [NUM_GATES-1:0] exp_o
);

    always_comb begin
        exp_o         = '0;
        exp_o[FM_AND] = a_i & b_i;
        exp_o[FM_OR]  = a_i | b_i;
        exp_o[FM_XOR] = a_i ^ b_i;
        exp_o[FM_NOT] = ~a_i;
        exp_o[FM_MUX] = sel_i ? b_i : a_i;
    end

endmodule : gate_golden_model
`default_nettype wire

// File: rtl/gate_bist_checker.sv
`default_nettype none
// ============================================================================
// Module   : gate_bist_checker
// Purpose  : Walks all {a,b,sel} vectors through the gate set, checks the
//            responses after a settle delay and accumulates error statistics.
// Revision : 1.0 - initial release
// ============================================================================
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,   // legal range 1..15
    parameter int ERR_W         = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 a,
    output logic                 b,
    output logic                 sel,
    input  logic                 y_and,
    input  logic                 y_or,
    input  logic                 y_xor,
    input  logic                 y_not,
    input  logic                 y_mux,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic [NUM_GATES-1:0] fail_mask,
    output logic [VEC_W-1:0]     first_fail_idx,
    output logic                 first_fail_valid
);

    localparam logic [CNT_W-1:0] C_SETTLE   = CNT_W'(SETTLE_CYCLES);
    localparam logic [ERR_W-1:0] C_ERR_MAX  = '1;
    localparam logic [VEC_W-1:0] C_LAST_IDX = VEC_W'(NUM_VECTORS - 1);

    state_t                 state_q, state_d;
    logic [VEC_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ERR_W-1:0]       err_q, err_d;
    logic [NUM_GATES-1:0]   mask_q, mask_d;
    logic [VEC_W-1:0]       ffi_q, ffi_d;
    logic                   ffv_q, ffv_d;

    logic [NUM_GATES-1:0]   w_expected;
    logic [NUM_GATES-1:0]   w_observed;
    logic [NUM_GATES-1:0]   w_miss;

    // The vector index register doubles as the registered stimulus.
    assign a   = idx_q[A_BIT];
    assign b   = idx_q[B_BIT];
    assign sel = idx_q[SEL_BIT];

    gate_golden_model u_golden (
        .a_i   (idx_q[A_BIT]),
        .b_i   (idx_q[B_BIT]),
        .sel_i (idx_q[SEL_BIT]),
        .exp_o (w_expected)
    );

    always_comb begin
        w_observed         = '0;
        w_observed[FM_AND] = y_and;
        w_observed[FM_OR]  = y_or;
        w_observed[FM_XOR] = y_xor;
        w_observed[FM_NOT] = y_not;
        w_observed[FM_MUX] = y_mux;
    end

    assign w_miss = w_observed ^ w_expected;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        mask_d  = mask_q;
        ffi_d   = ffi_q;
        ffv_d   = ffv_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_d   = '0;
                    mask_d  = '0;
                    ffi_d   = '0;
                    ffv_d   = 1'b0;
                    idx_d   = '0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                cnt_d   = C_SETTLE;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // One error per failing vector, however many gates disagree.
                if (|w_miss) begin
                    if (err_q != C_ERR_MAX) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!ffv_q) begin
                        ffi_d = idx_q;
                        ffv_d = 1'b1;
                    end
                end
                mask_d = mask_q | w_miss;
                if (idx_q == C_LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + VEC_W'(1);
                    state_d = ST_DRIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            mask_q  <= '0;
            ffi_q   <= '0;
            ffv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            ffi_q   <= ffi_d;
            ffv_q   <= ffv_d;
        end
    end

    assign busy             = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) ||
                              (state_q == ST_CHECK);
    assign done             = (state_q == ST_DONE);
    assign pass             = done && (err_q == '0);
    assign err_count        = err_q;
    assign fail_mask        = mask_q;
    assign first_fail_idx   = ffi_q;
    assign first_fail_valid = ffv_q;

endmodule : gate_bist_checker
`default_nettype wire

// File: tb/tb_gate_bist_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_bist_checker
// Purpose  : Self-checking bench; gates are modelled with a per-vector
//            corruption table and results predicted from that table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_bist_checker;

    localparam int TB_SETTLE = 2;
    localparam int TB_ERR_W  = 2;
    localparam int RUN_LEN   = 8 * (TB_SETTLE + 2);

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                a, b, sel;
    logic                y_and, y_or, y_xor, y_not, y_mux;
    logic                busy, done, pass;
    logic [TB_ERR_W-1:0] err_count;
    logic [4:0]          fail_mask;
    logic [2:0]          first_fail_idx;
    logic                first_fail_valid;

    int checks = 0;
    int errors = 0;

    // Per-vector XOR applied to the ideal gate outputs: bit0 and .. bit4 mux.
    logic [4:0] corrupt [8];

    logic [2:0] v;
    logic [4:0] g, y;

    always #5 clk = ~clk;

    gate_bist_checker #(
        .SETTLE_CYCLES (TB_SETTLE),
        .ERR_W         (TB_ERR_W)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .a                (a),
        .b                (b),
        .sel              (sel),
        .y_and            (y_and),
        .y_or             (y_or),
        .y_xor            (y_xor),
        .y_not            (y_not),
        .y_mux            (y_mux),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .fail_mask        (fail_mask),
        .first_fail_idx   (first_fail_idx),
        .first_fail_valid (first_fail_valid)
    );

    always_comb begin
        v = {a, b, sel};
        g = {(sel ? b : a), ~a, a ^ b, a | b, a & b};
        y = g ^ corrupt[v];
    end
    assign y_and = y[0];
    assign y_or  = y[1];
    assign y_xor = y[2];
    assign y_not = y[3];
    assign y_mux = y[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 good, 1 and stuck 0, 2 mux select inverted, 3 not wired to a,
    // 4 random faults, 5 xor flipped everywhere
    task automatic set_table(input int mode);
        for (int i = 0; i < 8; i++) begin
            int ia, ib;
            ia = (i >> 2) & 1;
            ib = (i >> 1) & 1;
            corrupt[i] = 5'b0;
            case (mode)
                1: corrupt[i][0] = 1'(ia & ib);
                2: corrupt[i][4] = 1'(ia ^ ib);
                3: corrupt[i][3] = 1'b1;
                4: corrupt[i]    = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'b0;
                5: corrupt[i][2] = 1'b1;
                default: corrupt[i] = 5'b0;
            endcase
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic full_run(input string tag);
        int         n_fail;
        logic [4:0] e_mask;
        int         e_ffi;
        logic       e_ffv;
        int         e_err;
        n_fail = 0; e_mask = 5'b0; e_ffi = 0; e_ffv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (corrupt[i] != 5'b0) begin
                n_fail++;
                e_mask = e_mask | corrupt[i];
                if (!e_ffv) begin
                    e_ffi = i;
                    e_ffv = 1'b1;
                end
            end
        end
        e_err = (n_fail > (1 << TB_ERR_W) - 1) ? (1 << TB_ERR_W) - 1 : n_fail;

        pulse_start();
        for (int k = 0; k <= RUN_LEN; k++) begin
            @(negedge clk);
            if (k < RUN_LEN) begin
                chk({tag, ".vec"}, {29'b0, a, b, sel}, 32'(k / (TB_SETTLE + 2)));
                chk({tag, ".busy"}, {30'b0, busy, done}, 32'b10);
                if (k == 0)
                    chk({tag, ".cleared"}, {25'b0, err_count, fail_mask, first_fail_valid, pass}, 32'b0);
            end else begin
                chk({tag, ".done"}, {30'b0, done, busy}, 32'b10);
                chk({tag, ".pass"}, {31'b0, pass}, 32'(n_fail == 0));
                chk({tag, ".err"}, 32'(err_count), 32'(e_err));
                chk({tag, ".mask"}, 32'(fail_mask), 32'(e_mask));
                chk({tag, ".ffv"}, 32'(first_fail_valid), 32'(e_ffv));
                chk({tag, ".ffi"}, 32'(first_fail_idx), 32'(e_ffi));
            end
        end
        repeat (3) @(negedge clk);
        chk({tag, ".hold"}, {24'b0, done, pass, err_count, fail_mask[3:0]},
            {24'b0, 1'b1, 1'(n_fail == 0), 2'(e_err), e_mask[3:0]});
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        set_table(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset", {20'b0, a, b, sel, busy, done, pass, err_count, fail_mask,
                      first_fail_idx, first_fail_valid}, 32'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_hold", {30'b0, busy, done}, 32'b0);

        set_table(0); full_run("good");
        set_table(1); full_run("and0");
        set_table(2); full_run("muxinv");
        set_table(3); full_run("nota_sat");
        for (int r = 0; r < 4; r++) begin
            set_table(4); full_run($sformatf("rand%0d", r));
        end

        // Ignored start mid-run, then reset mid-flight.
        set_table(5);
        pulse_start();
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k < 10) chk("midrun.vec", {29'b0, a, b, sel}, 32'(k / (TB_SETTLE + 2)));
            if (k == 8) chk("midrun.err", 32'(err_count), 32'd2);
            if (k == 5) start = 1'b1;
            if (k == 6) start = 1'b0;
            if (k == 10) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        chk("midrst", {20'b0, a, b, sel, busy, done, pass, err_count, fail_mask,
                       first_fail_idx, first_fail_valid}, 32'b0);
        repeat (3) @(negedge clk);
        chk("midrst.idle", {29'b0, busy, done, a}, 32'b0);

        set_table(0); full_run("after_rst");
        set_table(1); full_run("b2b_fail");
        set_table(0); full_run("b2b_fixed");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_gate_bist_checker
`default_nettype wire
